writeback_pipe: RTL
===================

WRITEBACK_PIPE -- requirements
Module: writeback_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 7, giving the maximum unit latency in cycles and the number of slots.
REQ-002 SHALL have parameter DATA_W, default 128, giving the result width.
REQ-003 SHALL have parameter REG_W, default 7, giving the register-number width (128 registers).
REQ-004 SHALL use one clock and an asynchronous, active-high reset, with ports as follows.
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- ex_valid  in  1  execute result offered.
- ex_ready  out  1  result accepted this cycle.
- ex_result  in  DATA_W  ALUResult from execute.
- ex_rt  in  REG_W  selected destination register.
- ex_reg_write  in  1  result writes the register file.
- ex_latency  in  3  unit latency, 1..DEPTH.
- flush  in  1  discard all in-flight results.
- wb_stall  in  1  register-file port busy; freeze the pipe.
- wb_valid  out  1  writeback slot valid.
- wb_result  out  DATA_W  writeback data.
- wb_rt  out  REG_W  writeback register.
- wb_reg_write  out  1  register-file write enable (wb_valid and reg_write).
- hz_reg  in  REG_W  hazard query register.
- hz_pending  out  1  query register has an in-flight write.

Function
REQ-005 SHALL hold DEPTH slots s[0..DEPTH-1], each containing valid, result, rt and reg_write.
REQ-006 SHALL drive the wb_* outputs combinationally from s[0].
REQ-007 SHALL, on each clock edge without stall or flush, shift all slots: s[i] <= s[i+1], with s[DEPTH-1] becoming empty.
REQ-008 SHALL, on acceptance (ex_valid and ex_ready), write the entry into s[L-1] on the same edge, where L = ex_latency; the write overrides the shifted value.
REQ-009 SHALL treat an ex_latency of 0 as 1, and any value above DEPTH as DEPTH.
REQ-010 SHALL deassert ex_ready when reset, flush or wb_stall is high.
REQ-011 SHALL also deassert ex_ready when L < DEPTH and s[L].valid is set (writeback-port collision); ex_ready SHALL be otherwise high.
REQ-012 SHALL present an accepted result on wb_valid exactly L cycles after the acceptance cycle, plus one cycle per wb_stall cycle in between.
REQ-013 SHALL, while wb_stall is high, hold every slot unchanged; wb_* SHALL stay stable and no entry is accepted.
REQ-014 SHALL, when flush is high, clear every valid bit on the next edge; flush SHALL take priority over wb_stall and over acceptance.
REQ-015 SHALL, when flush and ex_valid are high together, drop the offered result.
REQ-016 SHALL drive hz_pending high iff some slot is valid with reg_write=1 and rt==hz_reg; s[0] counts even while stalled.
REQ-017 SHALL preserve result order for equal latencies; different latencies MAY complete out of issue order.
REQ-018 SHALL accept a latency-DEPTH entry on every cycle, since it never collides.
REQ-019 SHALL keep wb_reg_write low whenever wb_valid is low.

Reset
REQ-020 SHALL, on reset assertion, immediately clear all slot valid bits and zero all result/rt fields, without waiting for a clock edge.
REQ-021 SHALL hold wb_valid=0, wb_reg_write=0, wb_result=0, wb_rt=0, hz_pending=0 and ex_ready=0 while reset is high.
REQ-022 SHALL discard any in-flight results if reset is asserted mid-operation; ex_ready SHALL rise in the first cycle after reset deasserts.

Structure
REQ-023 SHALL take the slot struct type (wb_slot_t), DEPTH, DATA_W and REG_W defaults from the shared package spu_pkg.
REQ-024 SHALL instantiate one sub-module, wb_slot_reg: one slot register with async reset, hold, load-shift and load-new selects, replicated DEPTH times.
REQ-025 SHALL keep the collision and hazard logic in the top level, not in the slot sub-module.

Verification
REQ-026 Single issue: latency 3, rt=5, result=0x...DEAD, accepted at cycle 10 -> wb_valid=1 at cycle 13 only, with wb_rt=5 and wb_reg_write=1.
REQ-027 Collision: latency-4 entry accepted at cycle 0, then latency 3 offered at cycle 1 -> ex_ready=0 at cycle 1; re-offer at cycle 2 is accepted, and the two results write back at cycles 4 and 5.
REQ-028 Stall: latency 1 accepted at cycle 0, wb_stall high in cycles 1-2 -> wb_valid held with unchanged data in cycles 1-3, then 0 at cycle 4.
REQ-029 Flush: three entries in flight (latencies 5, 6, 7) plus flush together with an offered entry -> all slots empty after the edge, and hz_pending=0 for every register.
REQ-030 Hazard: latency 7, rt=12 accepted -> hz_pending=1 for hz_reg=12 for 7 cycles, and 0 for hz_reg=13 throughout.
REQ-031 Reset mid-flight: reset asserted between clock edges with 4 entries valid -> wb_valid=0 before the next edge, and no writeback after release.

Source files
------------

// File: rtl/spu_pkg.sv
//------------------------------------------------------------------------------
// Module  : spu_pkg
// Brief   : Shared writeback-pipe types, default widths and latency helper.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package spu_pkg;

    localparam int DEPTH_DEF  = 7;
    localparam int DATA_W_DEF = 128;
    localparam int REG_W_DEF  = 7;
    localparam int LAT_W      = 3;

    typedef struct packed {
        logic                  valid;
        logic [DATA_W_DEF-1:0] result;
        logic [REG_W_DEF-1:0]  rt;
        logic                  reg_write;
    } wb_slot_t;

    // Zero latency behaves as one; anything past the pipe depth lands in the last slot.
    function automatic logic [LAT_W-1:0] clamp_latency(input logic [LAT_W-1:0] lat,
                                                       input logic [LAT_W-1:0] max_lat);
        if (lat == '0)
            return LAT_W'(1);
        else if (lat > max_lat)
            return max_lat;
        else
            return lat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/writeback_pipe_if.sv
//------------------------------------------------------------------------------
// Module  : writeback_pipe_if
// Brief   : Execute-side offer, writeback port and hazard query bundle.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface writeback_pipe_if
    import spu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
);
    logic              ex_valid;
    logic              ex_ready;
    logic [DATA_W-1:0] ex_result;
    logic [REG_W-1:0]  ex_rt;
    logic              ex_reg_write;
    logic [LAT_W-1:0]  ex_latency;
    logic              flush;
    logic              wb_stall;
    logic              wb_valid;
    logic [DATA_W-1:0] wb_result;
    logic [REG_W-1:0]  wb_rt;
    logic              wb_reg_write;
    logic [REG_W-1:0]  hz_reg;
    logic              hz_pending;

    modport master (
        output ex_valid, ex_result, ex_rt, ex_reg_write, ex_latency,
        output flush, wb_stall, hz_reg,
        input  ex_ready, wb_valid, wb_result, wb_rt, wb_reg_write, hz_pending
    );

    modport slave (
        input  ex_valid, ex_result, ex_rt, ex_reg_write, ex_latency,
        input  flush, wb_stall, hz_reg,
        output ex_ready, wb_valid, wb_result, wb_rt, wb_reg_write, hz_pending
    );

endinterface

`default_nettype wire

// File: rtl/wb_slot_reg.sv
//------------------------------------------------------------------------------
// Module  : wb_slot_reg
// Brief   : One writeback slot register: clear / hold / load-new / shift.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module wb_slot_reg
    import spu_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     i_clear,
    input  wire logic     i_hold,
    input  wire logic     i_load_new,
    input  wire wb_slot_t i_shift,
    input  wire wb_slot_t i_new,
    output wb_slot_t      o_slot
);

    wb_slot_t slot_d;
    wb_slot_t slot_q;

    // Clear only drops the valid bit; payload is don't-care once invalid.
    always_comb begin
        slot_d = slot_q;
        if (i_clear) begin
            slot_d.valid = 1'b0;
        end else if (!i_hold) begin
            if (i_load_new)
                slot_d = i_new;
            else
                slot_d = i_shift;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            slot_q <= '0;
        else
            slot_q <= slot_d;
    end

    assign o_slot = slot_q;

endmodule

`default_nettype wire

// File: rtl/writeback_pipe.sv
//------------------------------------------------------------------------------
// Module  : writeback_pipe
// Brief   : Latency-slotted writeback shift pipe with collision and hazard logic.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module writeback_pipe
    import spu_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_W  = REG_W_DEF
)(
    input  wire logic        clk,
    input  wire logic        reset,
    writeback_pipe_if.slave  bus
);

    wb_slot_t         slot_q [DEPTH];
    wb_slot_t         w_new_entry;
    logic [LAT_W-1:0] w_lat;
    logic             w_collide;
    logic             w_ready;
    logic             w_accept;
    logic             w_hz;

    always_comb begin
        w_lat                 = clamp_latency(bus.ex_latency, LAT_W'(DEPTH));
        w_new_entry.valid     = 1'b1;
        w_new_entry.result    = DATA_W_DEF'(bus.ex_result);
        w_new_entry.rt        = REG_W_DEF'(bus.ex_rt);
        w_new_entry.reg_write = bus.ex_reg_write;
    end

    // Slot L will shift into s[L-1] on the same edge the new entry targets.
    always_comb begin
        w_collide = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if (w_lat == LAT_W'(i) && slot_q[i].valid)
                w_collide = 1'b1;
        end
    end

    assign w_ready  = !reset && !bus.flush && !bus.wb_stall && !w_collide;
    assign w_accept = bus.ex_valid && w_ready;

    always_comb begin
        w_hz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_q[i].valid && slot_q[i].reg_write &&
                slot_q[i].rt == REG_W_DEF'(bus.hz_reg))
                w_hz = 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            wb_slot_t w_shift;
            if (gi == DEPTH - 1) begin : g_tail
                assign w_shift = '0;
            end else begin : g_body
                assign w_shift = slot_q[gi+1];
            end

            wb_slot_reg u_slot (
                .clk        (clk),
                .rst        (reset),
                .i_clear    (bus.flush),
                .i_hold     (bus.wb_stall),
                .i_load_new (w_accept && (w_lat == LAT_W'(gi + 1))),
                .i_shift    (w_shift),
                .i_new      (w_new_entry),
                .o_slot     (slot_q[gi])
            );
        end
    endgenerate

    assign bus.ex_ready     = w_ready;
    assign bus.wb_valid     = slot_q[0].valid;
    assign bus.wb_reg_write = slot_q[0].valid && slot_q[0].reg_write;
    assign bus.wb_result    = DATA_W'(slot_q[0].result);
    assign bus.wb_rt        = REG_W'(slot_q[0].rt);
    assign bus.hz_pending   = w_hz;

endmodule

`default_nettype wire
